// File: rtl/filter_pkg.sv
// Shared widths and drain-FSM state type for the sum RAM, controller and sum_tx_serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro: SUM_TX_CHECKSUM_EN adds the CKSUM state to the enum.
package filter_pkg;

  localparam int SUM_W      = 40;
  localparam int SUM_BYTES  = SUM_W / 8;
  localparam int SUM_DEPTH  = 768;
  localparam int SUM_ADDR_W = 10;
  localparam int SUM_RD_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_SEND,
    ST_ACK,
`ifdef SUM_TX_CHECKSUM_EN
    ST_CKSUM,
`endif
    ST_FIN
  } tx_state_e;

endpackage

// File: rtl/sum_tx_shifter.sv
// Word shift register: loads one sum word, presents its top byte, shifts left by 8 per byte sent.
// Latency: load/shift take effect on the next clock; o_byte/o_empty are direct register decodes.
// Backpressure: none internally; the parent only pulses i_shift when the transmitter takes a byte.
// Ports: i_load/i_data load a word and clear the byte count; i_shift advances one byte;
//        o_byte is the current MSB byte; o_empty is high once all BYTES bytes have been shifted.
module sum_tx_shifter #(
  parameter int DATA_W = 40,
  parameter int BYTES  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_shift,
  output logic [7:0]        o_byte,
  output logic              o_empty
);

  localparam int CNT_W = $clog2(BYTES + 1);

  logic [DATA_W-1:0] r_sh;
  logic [CNT_W-1:0]  r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= i_data;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_sh  <= {r_sh[DATA_W-9:0], 8'h00};
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_byte  = r_sh[DATA_W-1 -: 8];
  assign o_empty = (r_cnt == CNT_W'(BYTES));

endmodule

// File: rtl/sum_tx_serializer.sv
// Drains DEPTH sum words from the sum RAM and streams each MSB-first as BYTES bytes to the UART.
// Latency: start -> rd_en 1 cycle; rd_en -> word captured RD_LAT cycles; byte strobe 1 cycle after tx_rdy.
// Backpressure: each byte waits for tx_rdy=1, then for tx_rdy=0 as the acceptance; nothing is dropped.
// Ports: clk/reset (sync, active-high); start pulse; rd_addr/rd_en/rd_data to the sum RAM;
//        tx_data/tx_en/tx_rdy to the UART; busy spans the frame, done pulses once at the end.
// Optional feature macro: SUM_TX_CHECKSUM_EN appends an XOR-of-all-bytes trailer byte to the frame.
module sum_tx_serializer
  import filter_pkg::*;
#(
  parameter int DATA_W = SUM_W,
  parameter int BYTES  = SUM_BYTES,
  parameter int ADDR_W = SUM_ADDR_W,
  parameter int DEPTH  = SUM_DEPTH,
  parameter int RD_LAT = SUM_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_en,
  input  logic              tx_rdy,
  output logic              busy,
  output logic              done
);

  tx_state_e         r_state;
  tx_state_e         w_next;
  logic [ADDR_W-1:0] r_word;
  logic [1:0]        r_lat;
  logic [7:0]        r_tx_data;
  logic              r_tx_en;
  logic              w_load;
  logic              w_shift;
  logic [7:0]        w_byte;
  logic              w_empty;
`ifdef SUM_TX_CHECKSUM_EN
  logic [7:0]        r_xor;
  logic              r_ck_sent;
`endif

  sum_tx_shifter #(.DATA_W(DATA_W), .BYTES(BYTES)) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_data  (rd_data),
    .i_shift (w_shift),
    .o_byte  (w_byte),
    .o_empty (w_empty)
  );

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_READ;
      ST_READ: w_next = ST_WAIT;
      // r_lat counts cycles since rd_en; the word is on rd_data when it reaches RD_LAT.
      ST_WAIT: if (r_lat == 2'(RD_LAT)) begin
        w_load = 1'b1;
        w_next = ST_SEND;
      end
      ST_SEND: if (tx_rdy) begin
        w_shift = 1'b1;
        w_next  = ST_ACK;
      end
      // tx_rdy falling is the transmitter's acknowledgement of the strobed byte.
      ST_ACK: if (!tx_rdy) begin
`ifdef SUM_TX_CHECKSUM_EN
        if (r_ck_sent)
          w_next = ST_FIN;
        else if (!w_empty)
          w_next = ST_SEND;
        else if (r_word == ADDR_W'(DEPTH - 1))
          w_next = ST_CKSUM;
        else
          w_next = ST_READ;
`else
        if (!w_empty)
          w_next = ST_SEND;
        else if (r_word == ADDR_W'(DEPTH - 1))
          w_next = ST_FIN;
        else
          w_next = ST_READ;
`endif
      end
`ifdef SUM_TX_CHECKSUM_EN
      ST_CKSUM: if (tx_rdy) w_next = ST_ACK;
`endif
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_word    <= '0;
      r_lat     <= '0;
      r_tx_data <= '0;
      r_tx_en   <= 1'b0;
`ifdef SUM_TX_CHECKSUM_EN
      r_xor     <= '0;
      r_ck_sent <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_tx_en <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_word <= '0;
`ifdef SUM_TX_CHECKSUM_EN
          r_xor     <= '0;
          r_ck_sent <= 1'b0;
`endif
        end
        ST_READ: r_lat <= 2'd1;
        ST_WAIT: r_lat <= r_lat + 2'd1;
        ST_SEND: if (tx_rdy) begin
          r_tx_data <= w_byte;
          r_tx_en   <= 1'b1;
`ifdef SUM_TX_CHECKSUM_EN
          r_xor     <= r_xor ^ w_byte;
`endif
        end
        ST_ACK: if (w_next == ST_READ) r_word <= r_word + ADDR_W'(1);
`ifdef SUM_TX_CHECKSUM_EN
        ST_CKSUM: if (tx_rdy) begin
          r_tx_data <= r_xor;
          r_tx_en   <= 1'b1;
          r_ck_sent <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign rd_addr = r_word;
  assign rd_en   = (r_state == ST_READ);
  assign tx_data = r_tx_data;
  assign tx_en   = r_tx_en;
  assign busy    = (r_state != ST_IDLE) && (r_state != ST_FIN);
  assign done    = (r_state == ST_FIN);

endmodule

// File: tb/tb_sum_tx_serializer.sv
// Bench for sum_tx_serializer: instance 0 runs full 768-word frames, instance 1 a single-word frame.
// A frame-level model expands RAM contents into the expected byte stream on each accepted start.
module tb_sum_tx_serializer;

  localparam int DEPTH_A = 768;
`ifdef SUM_TX_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start   [2];
  logic [9:0]  rd_addr [2];
  logic        rd_en   [2];
  logic [39:0] rd_data [2];
  logic [7:0]  tx_data [2];
  logic        tx_en   [2];
  logic        tx_rdy  [2];
  logic        busy    [2];
  logic        done    [2];

  logic [39:0] ram  [2][DEPTH_A];
  logic [39:0] pipe [2][3];
  logic [7:0]  expb [2][4096];
  logic [7:0]  gotb [2][4096];
  int exp_n[2], n_str[2], rd_next[2], n_done[2];
  int lo_min[2], lo_max[2], bp_at[2], lo_cnt[2];
  bit drop_pend[2], m_busy[2], prev_en[2], prev_rdy[2];
  logic [7:0] prev_dat[2];
  bit rst_prev = 1'b0;
  int vectors = 0;
  int errors = 0;

  function automatic void chk(string name, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  sum_tx_serializer #(.DEPTH(DEPTH_A), .RD_LAT(2)) dut_a (
    .clk(clk), .reset(reset), .start(start[0]), .rd_addr(rd_addr[0]), .rd_en(rd_en[0]),
    .rd_data(rd_data[0]), .tx_data(tx_data[0]), .tx_en(tx_en[0]), .tx_rdy(tx_rdy[0]),
    .busy(busy[0]), .done(done[0]));

  sum_tx_serializer #(.DEPTH(1), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .start(start[1]), .rd_addr(rd_addr[1]), .rd_en(rd_en[1]),
    .rd_data(rd_data[1]), .tx_data(tx_data[1]), .tx_en(tx_en[1]), .tx_rdy(tx_rdy[1]),
    .busy(busy[1]), .done(done[1]));

  // Sum RAM: data appears RD_LAT cycles after rd_en; garbage otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      pipe[i][0] <= rd_en[i] ? ram[i][rd_addr[i]] : 40'hA5_5A5A_A55A;
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end
  assign rd_data[0] = pipe[0][1];
  assign rd_data[1] = pipe[1][2];

  // UART model: tx_rdy drops one cycle after a strobe and returns after a hold time.
  initial begin
    tx_rdy[0] = 1'b1;
    tx_rdy[1] = 1'b1;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (lo_cnt[i] > 0) begin
          lo_cnt[i]--;
          if (lo_cnt[i] == 0) tx_rdy[i] = 1'b1;
        end else if (drop_pend[i]) begin
          drop_pend[i] = 1'b0;
          tx_rdy[i]    = 1'b0;
          lo_cnt[i]    = (n_str[i] == bp_at[i]) ? 500 : int'($urandom_range(lo_max[i], lo_min[i]));
        end else if (tx_en[i]) begin
          drop_pend[i] = 1'b1;
        end
      end
    end
  end

  // Frame model and per-cycle compare.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int dep;
      logic [7:0] x;
      logic [39:0] wd;
      dep = (i == 0) ? DEPTH_A : 1;
      if (reset) begin
        if (rst_prev) begin
          chk("rst_rd_en", rd_en[i], 0);
          chk("rst_rd_addr", rd_addr[i], 0);
          chk("rst_tx_en", tx_en[i], 0);
          chk("rst_tx_data", tx_data[i], 0);
          chk("rst_busy", busy[i], 0);
          chk("rst_done", done[i], 0);
        end
        m_busy[i] = 1'b0;
      end else begin
        if (done[i]) begin
          chk("done_in_frame", m_busy[i], 1);
          chk("done_bytes", n_str[i], exp_n[i]);
          chk("done_reads", rd_next[i], dep);
          n_done[i]++;
          m_busy[i] = 1'b0;
        end
        chk("busy", busy[i], m_busy[i]);
        if (rd_en[i]) begin
          chk("rd_en_busy", m_busy[i], 1);
          chk("rd_addr", rd_addr[i], rd_next[i]);
          rd_next[i]++;
        end
        if (tx_en[i]) begin
          chk("tx_en_busy", m_busy[i], 1);
          chk("tx_en_gap", prev_en[i], 0);
          chk("tx_en_rdy", prev_rdy[i], 1);
          chk("tx_data", tx_data[i], (n_str[i] < exp_n[i]) ? {1'b0, expb[i][n_str[i]]} : 9'h100);
          if (n_str[i] < 4096) gotb[i][n_str[i]] = tx_data[i];
          n_str[i]++;
        end else if (!rst_prev) begin
          chk("tx_hold", tx_data[i], prev_dat[i]);
        end
        if (start[i] && !m_busy[i] && !done[i]) begin
          exp_n[i] = 0;
          x = 8'h00;
          for (int w = 0; w < dep; w++) begin
            wd = ram[i][w];
            for (int b = 0; b < 5; b++) begin
              expb[i][exp_n[i]] = wd[39 - 8*b -: 8];
              x ^= wd[39 - 8*b -: 8];
              exp_n[i]++;
            end
          end
          if (CK == 1) begin
            expb[i][exp_n[i]] = x;
            exp_n[i]++;
          end
          m_busy[i]  = 1'b1;
          rd_next[i] = 0;
          n_str[i]   = 0;
        end
      end
      prev_en[i]  = tx_en[i];
      prev_rdy[i] = tx_rdy[i];
      prev_dat[i] = tx_data[i];
    end
    rst_prev = reset;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int lim);
    int n = 0;
    while (!done[i] && n < lim) begin
      tick();
      n++;
    end
    chk("done_timeout", (n < lim), 1);
    tick();
  endtask

  initial begin
    logic [7:0] lit_b [5];
    logic [7:0] lit_a [5];
    int s_str, s_rd;
    lit_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    lit_a = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hFF};
    lo_min = '{1, 10};
    lo_max = '{3, 10};
    bp_at  = '{-1, -1};

    // Reset for 3 cycles with start held high: reset must win.
    reset = 1'b1;
    start[0] = 1'b1;
    start[1] = 1'b1;
    tick(3);
    reset = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    tick(3);
    chk("post_rst_reads", rd_next[0] + rd_next[1], 0);

    // Single word, slow UART (returns 10 cycles after dropping).
    ram[1][0] = 40'h12_3456_789A;
    pulse(1);
    wait_done(1, 2000);
    chk("b_nbytes", n_str[1], 5 + CK);
    for (int k = 0; k < 5; k++) chk("b_byte", gotb[1][k], lit_b[k]);
    tick(20);
    chk("b_done_once", n_done[1], 1);
    chk("b_busy_low", busy[1], 0);

`ifdef SUM_TX_CHECKSUM_EN
    ram[1][0] = 40'h01_0203_0405;
    pulse(1);
    wait_done(1, 2000);
    chk("ck_nbytes", n_str[1], 6);
    chk("ck_trailer", gotb[1][5], 8'h01);
`endif

    // Random single-word frames with a fast UART.
    lo_min[1] = 1;
    lo_max[1] = 3;
    for (int f = 0; f < 20; f++) begin
      ram[1][0] = {8'($urandom), $urandom};
      tick($urandom_range(3, 0));
      pulse(1);
      wait_done(1, 2000);
    end

    // Full frame RAM[n]=n, 500-cycle stall after the 1003rd byte (mid-word).
    for (int n = 0; n < DEPTH_A; n++) ram[0][n] = 40'(n);
    bp_at[0] = 1003;
    pulse(0);
    wait_done(0, 60000);
    chk("a_nbytes", n_str[0], 3840 + CK);
    for (int k = 0; k < 5; k++) chk("a_last_word", gotb[0][3835 + k], lit_a[k]);
    chk("a_done_once", n_done[0], 1);

    // Second start while busy is ignored; reset after byte 7 aborts the frame.
    bp_at[0] = -1;
    for (int n = 0; n < DEPTH_A; n++) ram[0][n] = {8'($urandom), $urandom};
    pulse(0);
    tick(5);
    pulse(0);
    for (int n = 0; n < 2000 && n_str[0] < 7; n++) tick();
    chk("abort_reached_7", n_str[0], 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    s_str = n_str[0];
    s_rd  = rd_next[0];
    tick(50);
    chk("abort_no_tx", n_str[0], s_str);
    chk("abort_no_rd", rd_next[0], s_rd);
    pulse(0);
    wait_done(0, 60000);
    chk("a2_nbytes", n_str[0], 3840 + CK);
    chk("a2_done_total", n_done[0], 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
